// File: rtl/clock_strobe_pkg.sv
// ---------------------------------------------------------------------------
// clock_strobe_pkg
//   Shared definitions for the programmable multi-channel strobe generator.
//   - MODE_STROBE / MODE_SQUARE : per-channel output mode encoding
//   - idx_width()               : width of a channel index (never below 1)
// ---------------------------------------------------------------------------
package clock_strobe_pkg;

  localparam logic MODE_STROBE = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  // A single-channel build still needs a 1-bit select port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_strobe_channel.sv
// ---------------------------------------------------------------------------
// clock_strobe_channel
//   One divider channel: holds its own divisor, counts enabled cycles and
//   emits a registered 1-cycle strobe every r_div enabled cycles, plus a
//   square wave toggling on each strobe when in square mode.
// Ports
//   clock, reset_n : system clock, synchronous active-low reset
//   i_ld, i_ld_div : load new divisor (restarts count, clears square)
//   i_clr          : restart in phase (cnt=0, square=0), divisor kept
//   i_en           : count enable; low holds count and square
//   i_mode         : MODE_STROBE or MODE_SQUARE
//   o_strobe       : 1-cycle clock-enable pulse
//   o_square       : registered square-wave level
// ---------------------------------------------------------------------------
module clock_strobe_channel
  import clock_strobe_pkg::*;
#(
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 25000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_ld,
  input  logic [CNT_W-1:0] i_ld_div,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_mode,
  output logic             o_strobe,
  output logic             o_square
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_strobe;
  logic             r_square;

  logic w_terminal;
  logic w_hold_square;

  // r_div is never 0 on this path (div==0 is handled before the compare),
  // so the subtraction cannot wrap.
  assign w_terminal    = (r_cnt == r_div - ONE);
  // Leaving square mode forces the level low; staying in it holds the level.
  assign w_hold_square = (i_mode == MODE_SQUARE) & r_square;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the reset is synchronous, so it lives inside this block.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_div    <= DIV_RST;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_square <= 1'b0;
    end else if (i_ld) begin
      r_div    <= i_ld_div;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_square <= 1'b0;
    end else if (i_clr) begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_square <= 1'b0;
    end else if (!i_en || (r_div == '0)) begin
      // Paused or halted: count held (already 0 when halted), no strobe.
      r_strobe <= 1'b0;
      r_square <= w_hold_square;
    end else if (w_terminal) begin
      r_cnt    <= '0;
      r_strobe <= 1'b1;
      r_square <= (i_mode == MODE_SQUARE) ? ~r_square : 1'b0;
    end else begin
      r_cnt    <= r_cnt + ONE;
      r_strobe <= 1'b0;
      r_square <= w_hold_square;
    end
  end

  assign o_strobe = r_strobe;
  assign o_square = r_square;

endmodule

// File: rtl/clock_strobe_gen.sv
// ---------------------------------------------------------------------------
// clock_strobe_gen
//   Runtime-programmable multi-channel clock divider producing clock-enable
//   strobes and square-wave levels (beat tick, note scroll, LED blink).
// Ports
//   clock, reset_n : system clock, synchronous active-low reset
//   enable[NUM_CH] : per-channel run enable
//   mode[NUM_CH]   : 0 = strobe only, 1 = strobe + square
//   sync_clear     : restart every channel in phase
//   load_valid/load_ch/load_div : divisor load request
//   load_ready     : load can be accepted (high from first edge out of reset)
//   strobe[NUM_CH] : 1-cycle pulse every div enabled cycles
//   square[NUM_CH] : toggles on each strobe in square mode
// ---------------------------------------------------------------------------
module clock_strobe_gen
  import clock_strobe_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 25000000
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_CH-1:0]               enable,
  input  logic [NUM_CH-1:0]               mode,
  input  logic                            sync_clear,
  input  logic                            load_valid,
  input  logic [idx_width(NUM_CH)-1:0]    load_ch,
  input  logic [CNT_W-1:0]                load_div,
  output logic                            load_ready,
  output logic [NUM_CH-1:0]               strobe,
  output logic [NUM_CH-1:0]               square
);

  localparam int IDX_W = idx_width(NUM_CH);

  logic              r_load_ready;
  logic              w_accept;
  logic [NUM_CH-1:0] w_ld;

  // No back-pressure: ready simply tracks "out of reset for at least one edge".
  always_ff @(posedge clock) begin
    r_load_ready <= reset_n;
  end

  assign load_ready = r_load_ready;
  assign w_accept   = load_valid & r_load_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // An out-of-range load_ch matches no channel, so the load is dropped.
    assign w_ld[g] = w_accept & (load_ch == IDX_W'(g));

    clock_strobe_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_ld     (w_ld[g]),
      .i_ld_div (load_div),
      .i_clr    (sync_clear),
      .i_en     (enable[g]),
      .i_mode   (mode[g]),
      .o_strobe (strobe[g]),
      .o_square (square[g])
    );
  end

endmodule

// File: tb/tb_clock_strobe_gen.sv
module tb_clock_strobe_gen;

  localparam int CNT_W = 8;
  localparam int DEF   = 5;

  logic       clock = 1'b0;
  logic       reset_n, sync_clear, load_valid;
  logic [3:0] enable, mode;
  logic [1:0] load_ch;
  logic [7:0] load_div;

  logic [3:0] a_strobe, a_square;
  logic       a_ready;
  logic [2:0] b_strobe, b_square;
  logic       b_ready;

  always #5 clock = ~clock;

  // Four-channel instance: every load_ch value is a real channel.
  clock_strobe_gen #(.NUM_CH(4), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
    .sync_clear(sync_clear), .load_valid(load_valid), .load_ch(load_ch),
    .load_div(load_div), .load_ready(a_ready), .strobe(a_strobe), .square(a_square)
  );

  // Three-channel instance: load_ch == 3 is out of range and must be ignored.
  clock_strobe_gen #(.NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable[2:0]), .mode(mode[2:0]),
    .sync_clear(sync_clear), .load_valid(load_valid), .load_ch(load_ch),
    .load_div(load_div), .load_ready(b_ready), .strobe(b_strobe), .square(b_square)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counts enabled cycles as a plain integer phase modulo the divisor.
  int m_div [2][4];
  int m_cnt [2][4];
  bit m_stb [2][4];
  bit m_sq  [2][4];
  bit m_rdy [2];
  bit acc;
  bit cmp_en = 1'b0;

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      acc = load_valid && m_rdy[d];
      for (int i = 0; i < nch(d); i++) begin
        if (!reset_n) begin
          m_div[d][i] = DEF; m_cnt[d][i] = 0; m_stb[d][i] = 0; m_sq[d][i] = 0;
        end else if (acc && int'(load_ch) == i) begin
          m_div[d][i] = int'(load_div); m_cnt[d][i] = 0; m_stb[d][i] = 0; m_sq[d][i] = 0;
        end else if (sync_clear) begin
          m_cnt[d][i] = 0; m_stb[d][i] = 0; m_sq[d][i] = 0;
        end else if (!enable[i] || m_div[d][i] == 0) begin
          m_stb[d][i] = 0;
          if (!mode[i]) m_sq[d][i] = 0;
        end else begin
          m_cnt[d][i] = (m_cnt[d][i] + 1) % m_div[d][i];
          m_stb[d][i] = (m_cnt[d][i] == 0);
          if (!mode[i]) m_sq[d][i] = 0;
          else if (m_stb[d][i]) m_sq[d][i] = !m_sq[d][i];
        end
      end
      m_rdy[d] = reset_n;
    end
  end

  function automatic logic [3:0] model_vec(input int d, input bit sel_square);
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < nch(d); i++) v[i] = sel_square ? m_sq[d][i] : m_stb[d][i];
    return v;
  endfunction

  // Single compare process: every cycle, both instances, all outputs.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("a_strobe", a_strobe, model_vec(0, 1'b0));
      check("a_square", a_square, model_vec(0, 1'b1));
      check("a_ready",  a_ready,  m_rdy[0]);
      check("b_strobe", b_strobe, model_vec(1, 1'b0) & 4'h7);
      check("b_square", b_square, model_vec(1, 1'b1) & 4'h7);
      check("b_ready",  b_ready,  m_rdy[1]);
    end
  end

  task automatic do_load(input logic [1:0] ch, input logic [7:0] dv);
    load_ch = ch; load_div = dv; load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  // ---------------- stimulus + literal pins ----------------
  initial begin
    int first;
    reset_n = 0; sync_clear = 0; load_valid = 0; load_ch = 0; load_div = 0;
    enable = 0; mode = 0;
    @(negedge clock);
    cmp_en = 1'b1;
    @(negedge clock);
    check("rst_strobe", a_strobe, 0);
    check("rst_square", a_square, 0);
    check("rst_ready",  a_ready,  0);

    // 1: default divisor, first strobe on 5th edge after release
    reset_n = 1; enable = 4'hF;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) check("ready_after_1", a_ready, 1);
      if (first == 0 && a_strobe[0]) begin
        first = k;
        check("all_ch_first", a_strobe, 4'hF);
      end
    end
    check("first_strobe_edge", first, 5);

    // 2: ch2 div=3 square mode
    mode[2] = 1'b1;
    do_load(2'd2, 8'd3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check($sformatf("ch2_strobe_%0d", k), a_strobe[2], (k % 3) == 0);
      check($sformatf("ch2_square_%0d", k), a_square[2], (k >= 3 && k <= 5));
    end

    // 3: ch1 div=0 silent, then div=1
    mode[1] = 1'b1;
    do_load(2'd1, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      check("ch1_halted", a_strobe[1], 0);
    end
    do_load(2'd1, 8'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check("ch1_div1_strobe", a_strobe[1], 1);
      check("ch1_div1_square", a_square[1], k % 2);
    end

    // 4: pause ch0 at cnt=2 for 7 cycles, resume continues the count
    do_load(2'd0, 8'd5);
    repeat (2) @(negedge clock);
    enable[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check("ch0_paused", a_strobe[0], 0);
    end
    enable[0] = 1'b1;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (first == 0 && a_strobe[0]) first = k;
    end
    check("ch0_resume_strobe", first, 3);

    // 5: load on ch3's terminal edge wins; then sync_clear realigns
    do_load(2'd3, 8'd4);
    repeat (3) @(negedge clock);
    load_ch = 2'd3; load_div = 8'd6; load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    check("load_wins_no_strobe", a_strobe[3], 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check($sformatf("ch3_div6_%0d", k), a_strobe[3], k == 6);
    end
    sync_clear = 1'b1;
    @(negedge clock);
    sync_clear = 1'b0;
    check("clear_strobe", a_strobe, 0);
    check("clear_square", a_square, 0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k == 15) check("align_15", a_strobe, 4'b0111);
      if (k == 30) check("align_30", a_strobe, 4'hF);
    end

    // Randomised traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      reset_n    = ($urandom_range(0, 299) != 0);
      sync_clear = ($urandom_range(0, 49) == 0);
      load_valid = ($urandom_range(0, 5) == 0);
      load_ch    = 2'($urandom_range(0, 3));
      load_div   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) enable[i] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) mode[$urandom_range(0, 3)] ^= 1'b1;
      @(negedge clock);
    end

    // 6: reset mid-count with a pending load; out-of-range load on 3-ch build
    reset_n = 1; sync_clear = 0; load_valid = 0; enable = 4'hF; mode = 0;
    repeat (3) @(negedge clock);
    reset_n = 0; load_valid = 1; load_ch = 2'd3; load_div = 8'd2;
    @(negedge clock);
    check("rst2_strobe", a_strobe, 0);
    check("rst2_square", a_square, 0);
    check("rst2_ready",  a_ready,  0);
    reset_n = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 2) load_valid = 0;
      if (k < 5) check("b_oor_quiet", b_strobe, 0);
      if (k == 4) check("a_ch3_div2", a_strobe, 4'b1000);
      if (k == 5) begin
        check("b_default_div", b_strobe, 3'h7);
        check("a_default_div", a_strobe, 4'b0111);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
